histogram_engine: RTL

HISTOGRAM_ENGINE -- requirements
Module: histogram_engine

---
 rtl/histogram_engine_if.sv | 32 +++
 rtl/histogram_engine.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/histogram_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : histogram_engine_if
// Description : Sample/control and bin-stream bundle for histogram_engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface histogram_engine_if #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 5
) ();
  logic              ENA;
  logic [DATA_W-1:0] d_in;
  logic              DUMP;
  logic              CLR;
  logic [DATA_W-1:0] bin_idx;
  logic [CNT_W-1:0]  bin_cnt;
  logic              bin_vld;
  logic              busy;
  logic              ovf;
  logic              drop;

  modport master (
    output ENA, d_in, DUMP, CLR,
    input  bin_idx, bin_cnt, bin_vld, busy, ovf, drop
  );

  modport slave (
    input  ENA, d_in, DUMP, CLR,
    output bin_idx, bin_cnt, bin_vld, busy, ovf, drop
  );
endinterface
`default_nettype wire

// File: rtl/histogram_engine.sv
`default_nettype none
// ============================================================================
// Module      : histogram_engine
// Description : Per-bin counting histogram with streamed dump of all bins.
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_engine #(
  parameter int DATA_W      = 7,
  parameter int CNT_W       = 5,
  parameter int SATURATE    = 1,
  parameter int CLR_ON_READ = 0
) (
  input wire CLK,
  input wire RST,
  histogram_engine_if.slave bus
);

  localparam int                c_nbins = 2**DATA_W;
  localparam logic [CNT_W-1:0]  c_max   = '1;
  localparam logic [DATA_W-1:0] c_last  = DATA_W'(c_nbins - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DUMP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic [CNT_W-1:0]  r_bins [c_nbins];
  logic [DATA_W-1:0] r_bin_idx;
  logic [DATA_W-1:0] w_idx_nxt;
  logic [DATA_W-1:0] w_idx_inc;
  logic [CNT_W-1:0]  r_bin_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cur;
  logic [CNT_W-1:0]  w_inc_val;
  logic              r_bin_vld;
  logic              w_vld_nxt;
  logic              r_busy;
  logic              r_ovf;
  logic              r_drop;
  logic              w_in_dump;
  logic              w_sample;
  logic              w_at_max;

  // Assertion is immediate; release reaches the core two edges later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n   = r_rst_sync[1];
  assign w_in_dump = (r_state == ST_DUMP);
  assign w_sample  = bus.ENA && !w_in_dump && !bus.CLR;
  assign w_cur     = r_bins[bus.d_in];
  assign w_at_max  = (w_cur == c_max);
  assign w_inc_val = w_at_max ? ((SATURATE != 0) ? c_max : '0) : w_cur + CNT_W'(1);
  assign w_idx_inc = r_bin_idx + DATA_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_bin_idx;
    w_cnt_nxt   = r_bin_cnt;
    w_vld_nxt   = 1'b0;
    if (bus.CLR) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          // Captured pre-edge, so a same-edge sample to bin 0 is not shown.
          if (bus.DUMP) begin
            w_state_nxt = ST_DUMP;
            w_idx_nxt   = '0;
            w_cnt_nxt   = r_bins[0];
            w_vld_nxt   = 1'b1;
          end
        end
        ST_DUMP: begin
          if (r_bin_idx == c_last) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_idx_nxt = w_idx_inc;
            w_cnt_nxt = r_bins[w_idx_inc];
            w_vld_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_RUN;
      r_bin_idx <= '0;
      r_bin_cnt <= '0;
      r_bin_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin_idx <= w_idx_nxt;
      r_bin_cnt <= w_cnt_nxt;
      r_bin_vld <= w_vld_nxt;
      r_busy    <= (w_state_nxt == ST_DUMP);
    end
  end

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
    end else if (bus.CLR) begin
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_sample && w_at_max) r_ovf <= 1'b1;
      if (bus.ENA && w_in_dump) r_drop <= 1'b1;
    end
  end

  // Samples are never accepted in DUMP, so read-clear cannot collide with them.
  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int b = 0; b < c_nbins; b++) r_bins[b] <= '0;
    end else if (bus.CLR) begin
      for (int b = 0; b < c_nbins; b++) r_bins[b] <= '0;
    end else if (w_sample) begin
      r_bins[bus.d_in] <= w_inc_val;
    end else if ((CLR_ON_READ != 0) && w_in_dump) begin
      r_bins[r_bin_idx] <= '0;
    end
  end

  assign bus.bin_idx = r_bin_idx;
  assign bus.bin_cnt = r_bin_cnt;
  assign bus.bin_vld = r_bin_vld;
  assign bus.busy    = r_busy;
  assign bus.ovf     = r_ovf;
  assign bus.drop    = r_drop;

endmodule
`default_nettype wire
